// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I instruction encoder with a single registered output beat.
// Optional LI pseudo-instruction expansion is compiled in when INSTR_ENC_LI_EN is defined.

module instr_encoder #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_in,
    output logic            req_ready_out,
    input  logic [3:0]      req_fmt_in,
    input  logic [4:0]      req_rd_in,
    input  logic [4:0]      req_rs1_in,
    input  logic [4:0]      req_rs2_in,
    input  logic [2:0]      req_funct3_in,
    input  logic [XLEN-1:0] req_imm_in,
    output logic            instr_valid_out,
    input  logic            instr_ready_in,
    output logic [ILEN-1:0] instr_out,
    output logic            err_out
);

    localparam logic [3:0] FMT_I_ALU = 4'd0;
    localparam logic [3:0] FMT_I_LD  = 4'd1;
    localparam logic [3:0] FMT_JALR  = 4'd2;
    localparam logic [3:0] FMT_S     = 4'd3;
    localparam logic [3:0] FMT_B     = 4'd4;
    localparam logic [3:0] FMT_LUI   = 4'd5;
    localparam logic [3:0] FMT_AUIPC = 4'd6;
    localparam logic [3:0] FMT_J     = 4'd7;
`ifdef INSTR_ENC_LI_EN
    localparam logic [3:0] FMT_LI    = 4'd8;
`endif

    localparam logic [6:0] OP_I_ALU = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_J     = 7'b1101111;

`ifdef INSTR_ENC_LI_EN
    typedef enum logic [1:0] {IDLE, LI_HI, LI_LO} state_t;
`else
    typedef enum logic [0:0] {IDLE} state_t;
`endif

    function automatic logic [ILEN-1:0] pack_i(input logic [11:0] imm, input logic [4:0] rs1,
                                               input logic [2:0] f3, input logic [4:0] rd,
                                               input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [ILEN-1:0] pack_s(input logic [11:0] imm, input logic [4:0] rs2,
                                               input logic [4:0] rs1, input logic [2:0] f3,
                                               input logic [6:0] op);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
    endfunction

    function automatic logic [ILEN-1:0] pack_b(input logic [12:1] imm, input logic [4:0] rs2,
                                               input logic [4:0] rs1, input logic [2:0] f3,
                                               input logic [6:0] op);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
    endfunction

    function automatic logic [ILEN-1:0] pack_u(input logic [31:12] imm, input logic [4:0] rd,
                                               input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [ILEN-1:0] pack_j(input logic [20:1] imm, input logic [4:0] rd,
                                               input logic [6:0] op);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
    endfunction

    state_t          state;
    state_t          next_state;
    logic            valid_q;
    logic [ILEN-1:0] instr_q;
    logic            err_q;
    logic            next_valid;
    logic [ILEN-1:0] next_instr;
    logic            next_err;

    logic            accept;
    logic            out_fire;
    logic            fits12;
    logic            fits13;
    logic            fits21;
    logic [ILEN-1:0] enc_instr;
    logic            enc_err;

`ifdef INSTR_ENC_LI_EN
    logic            enc_li_split;
    logic [19:0]     li_hi20;
    logic [4:0]      li_rd;
    logic [11:0]     li_lo12;
`endif

    assign req_ready_out   = rst_n && (state == IDLE) && (!valid_q || instr_ready_in);
    assign accept          = req_valid_in && req_ready_out;
    assign out_fire        = valid_q && instr_ready_in;
    assign instr_valid_out = valid_q;
    assign instr_out       = instr_q;
    assign err_out         = err_q;

    // A value fits in N signed bits when everything above bit N-2 is a copy of the sign.
    assign fits12 = (req_imm_in[XLEN-1:11] == '0) || (req_imm_in[XLEN-1:11] == '1);
    assign fits13 = (req_imm_in[XLEN-1:12] == '0) || (req_imm_in[XLEN-1:12] == '1);
    assign fits21 = (req_imm_in[XLEN-1:20] == '0) || (req_imm_in[XLEN-1:20] == '1);

`ifdef INSTR_ENC_LI_EN
    // Adding 0x800 only reaches bit 12 through imm[11], so the rounding needs a 20-bit adder.
    assign li_hi20 = req_imm_in[31:12] + {19'd0, req_imm_in[11]};
`endif

    always_comb begin
        enc_instr = '0;
        enc_err   = 1'b0;
`ifdef INSTR_ENC_LI_EN
        enc_li_split = 1'b0;
`endif
        case (req_fmt_in)
            FMT_I_ALU: begin
                enc_instr = pack_i(req_imm_in[11:0], req_rs1_in, req_funct3_in, req_rd_in, OP_I_ALU);
                enc_err   = !fits12;
            end
            FMT_I_LD: begin
                enc_instr = pack_i(req_imm_in[11:0], req_rs1_in, req_funct3_in, req_rd_in, OP_LD);
                enc_err   = !fits12;
            end
            FMT_JALR: begin
                enc_instr = pack_i(req_imm_in[11:0], req_rs1_in, req_funct3_in, req_rd_in, OP_JALR);
                enc_err   = !fits12;
            end
            FMT_S: begin
                enc_instr = pack_s(req_imm_in[11:0], req_rs2_in, req_rs1_in, req_funct3_in, OP_S);
                enc_err   = !fits12;
            end
            FMT_B: begin
                enc_instr = pack_b(req_imm_in[12:1], req_rs2_in, req_rs1_in, req_funct3_in, OP_B);
                enc_err   = !fits13 || req_imm_in[0];
            end
            FMT_LUI: begin
                enc_instr = pack_u(req_imm_in[31:12], req_rd_in, OP_LUI);
                enc_err   = (req_imm_in[11:0] != 12'd0);
            end
            FMT_AUIPC: begin
                enc_instr = pack_u(req_imm_in[31:12], req_rd_in, OP_AUIPC);
                enc_err   = (req_imm_in[11:0] != 12'd0);
            end
            FMT_J: begin
                enc_instr = pack_j(req_imm_in[20:1], req_rd_in, OP_J);
                enc_err   = !fits21 || req_imm_in[0];
            end
`ifdef INSTR_ENC_LI_EN
            FMT_LI: begin
                if (fits12) begin
                    enc_instr = pack_i(req_imm_in[11:0], 5'd0, 3'b000, req_rd_in, OP_I_ALU);
                end else begin
                    enc_instr    = pack_u(li_hi20, req_rd_in, OP_LUI);
                    enc_li_split = 1'b1;
                end
            end
`endif
            default: begin
                enc_instr = '0;
                enc_err   = 1'b1;
            end
        endcase
    end

    // Output register holds its beat until the downstream handshake, then loads the next one.
    always_comb begin
        next_state = state;
        next_valid = valid_q;
        next_instr = instr_q;
        next_err   = err_q;
        if (out_fire) begin
            next_valid = 1'b0;
        end
        case (state)
            IDLE: begin
                if (accept) begin
                    next_valid = 1'b1;
                    next_instr = enc_instr;
                    next_err   = enc_err;
`ifdef INSTR_ENC_LI_EN
                    if (enc_li_split) begin
                        next_state = LI_HI;
                    end
`endif
                end
            end
`ifdef INSTR_ENC_LI_EN
            LI_HI: begin
                if (out_fire) begin
                    if (li_lo12 != 12'd0) begin
                        next_valid = 1'b1;
                        next_instr = pack_i(li_lo12, li_rd, 3'b000, li_rd, OP_I_ALU);
                        next_err   = 1'b0;
                        next_state = LI_LO;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            LI_LO: begin
                if (out_fire) begin
                    next_state = IDLE;
                end
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= next_state;
            valid_q <= next_valid;
            instr_q <= next_instr;
            err_q   <= next_err;
        end
    end

`ifdef INSTR_ENC_LI_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            li_rd   <= 5'd0;
            li_lo12 <= 12'd0;
        end else if (accept) begin
            li_rd   <= req_rd_in;
            li_lo12 <= req_imm_in[11:0];
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table-driven vectors plus hand-written LI, backpressure and reset sequences,
// all checked through a scoreboard queue of expected output beats.

module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_in;
    logic        req_ready_out;
    logic [3:0]  req_fmt_in;
    logic [4:0]  req_rd_in;
    logic [4:0]  req_rs1_in;
    logic [4:0]  req_rs2_in;
    logic [2:0]  req_funct3_in;
    logic [31:0] req_imm_in;
    logic        instr_valid_out;
    logic        instr_ready_in = 1'b1;
    logic [31:0] instr_out;
    logic        err_out;

    typedef struct {
        logic [3:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        int          nbeats;
        logic [31:0] instr0;
        logic        err0;
        logic [31:0] instr1;
        logic        err1;
    } vec_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } beat_t;

    vec_t  vecs[$];
    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    beat_count = 0;
    int    ready_mode = 0;

    instr_encoder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .req_fmt_in     (req_fmt_in),
        .req_rd_in      (req_rd_in),
        .req_rs1_in     (req_rs1_in),
        .req_rs2_in     (req_rs2_in),
        .req_funct3_in  (req_funct3_in),
        .req_imm_in     (req_imm_in),
        .instr_valid_out(instr_valid_out),
        .instr_ready_in (instr_ready_in),
        .instr_out      (instr_out),
        .err_out        (err_out)
    );

    always #5 clk = ~clk;

    // Downstream ready: 0 = always ready, 1 = random, otherwise stalled.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       instr_ready_in = 1'b1;
            1:       instr_ready_in = 1'($urandom_range(0, 1));
            default: instr_ready_in = 1'b0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                                input int nb, input logic [31:0] i0, input logic e0,
                                input logic [31:0] i1, input logic e1);
        vec_t v;
        v.fmt = fmt; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.imm = imm;
        v.nbeats = nb; v.instr0 = i0; v.err0 = e0; v.instr1 = i1; v.err1 = e1;
        return v;
    endfunction

    // Every handshaken output beat is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && instr_valid_out && instr_ready_in) begin
            beat_count++;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_beat", instr_out, 32'hxxxxxxxx);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                checkOutput("beat_instr", instr_out, b.instr);
                checkOutput("beat_err", {31'd0, err_out}, {31'd0, b.err});
            end
        end
    end

    task automatic applyStimulus(input vec_t v, output int waited);
        req_fmt_in    = v.fmt;
        req_rd_in     = v.rd;
        req_rs1_in    = v.rs1;
        req_rs2_in    = v.rs2;
        req_funct3_in = v.f3;
        req_imm_in    = v.imm;
        req_valid_in  = 1'b1;
        waited = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (req_ready_out) begin
                exp_q.push_back({v.instr0, v.err0});
                if (v.nbeats == 2) exp_q.push_back({v.instr1, v.err1});
                waited = c;
            end
            @(posedge clk);
            #1;
            if (waited >= 0) break;
        end
        req_valid_in = 1'b0;
        if (waited < 0) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
        checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   w;
        int   bc;
        vec_t li_split;
        vec_t li_round;

        vecs.push_back(mk(4'd0, 5'd2, 5'd1, 5'd0, 3'd0, 32'hFFFFFFFF, 1, 32'hFFF08113, 1'b0, '0, 1'b0));
        vecs.push_back(mk(4'd1, 5'd3, 5'd2, 5'd0, 3'd2, 32'h000007FF, 1, 32'h7FF12183, 1'b0, '0, 1'b0));
        vecs.push_back(mk(4'd2, 5'd1, 5'd5, 5'd0, 3'd0, 32'hFFFFF800, 1, 32'h800280E7, 1'b0, '0, 1'b0));
        vecs.push_back(mk(4'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800, 1, 32'h80000093, 1'b1, '0, 1'b0));
        vecs.push_back(mk(4'd3, 5'd0, 5'd2, 5'd3, 3'd2, 32'hFFFFFFFC, 1, 32'hFE312E23, 1'b0, '0, 1'b0));
        vecs.push_back(mk(4'd4, 5'd0, 5'd1, 5'd0, 3'd0, 32'h00000008, 1, 32'h00008463, 1'b0, '0, 1'b0));
        vecs.push_back(mk(4'd4, 5'd0, 5'd1, 5'd0, 3'd0, 32'h00000007, 1, 32'h00008363, 1'b1, '0, 1'b0));
        vecs.push_back(mk(4'd4, 5'd0, 5'd1, 5'd2, 3'd1, 32'hFFFFF000, 1, 32'h80209063, 1'b0, '0, 1'b0));
        vecs.push_back(mk(4'd4, 5'd0, 5'd1, 5'd2, 3'd1, 32'h00001000, 1, 32'h80209063, 1'b1, '0, 1'b0));
        vecs.push_back(mk(4'd5, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345000, 1, 32'h123452B7, 1'b0, '0, 1'b0));
        vecs.push_back(mk(4'd5, 5'd5, 5'd0, 5'd0, 3'd0, 32'h00001001, 1, 32'h000012B7, 1'b1, '0, 1'b0));
        vecs.push_back(mk(4'd6, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFF000, 1, 32'hFFFFF097, 1'b0, '0, 1'b0));
        vecs.push_back(mk(4'd7, 5'd2, 5'd0, 5'd0, 3'd0, 32'h000FFFFE, 1, 32'h7FFFF16F, 1'b0, '0, 1'b0));
        vecs.push_back(mk(4'd7, 5'd2, 5'd0, 5'd0, 3'd0, 32'h00100000, 1, 32'h8000016F, 1'b1, '0, 1'b0));
        vecs.push_back(mk(4'd7, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFE, 1, 32'hFFFFF0EF, 1'b0, '0, 1'b0));
        vecs.push_back(mk(4'd9, 5'd1, 5'd1, 5'd1, 3'd1, 32'h00000001, 1, 32'h00000000, 1'b1, '0, 1'b0));
        vecs.push_back(mk(4'd15, 5'd3, 5'd3, 5'd3, 3'd7, 32'hFFFFFFFF, 1, 32'h00000000, 1'b1, '0, 1'b0));
`ifdef INSTR_ENC_LI_EN
        li_split = mk(4'd8, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345FFF, 2, 32'h123462B7, 1'b0, 32'hFFF28293, 1'b0);
        li_round = mk(4'd8, 5'd5, 5'd0, 5'd0, 3'd0, 32'h00003000, 1, 32'h000032B7, 1'b0, '0, 1'b0);
        vecs.push_back(mk(4'd8, 5'd7, 5'd0, 5'd0, 3'd0, 32'hFFFFFFFB, 1, 32'hFFB00393, 1'b0, '0, 1'b0));
        vecs.push_back(mk(4'd8, 5'd1, 5'd0, 5'd0, 3'd0, 32'h7FFFF800, 2, 32'h800000B7, 1'b0, 32'h80008093, 1'b0));
        vecs.push_back(mk(4'd8, 5'd3, 5'd0, 5'd0, 3'd0, 32'h00000800, 2, 32'h000011B7, 1'b0, 32'h80018193, 1'b0));
`else
        li_split = mk(4'd8, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345FFF, 1, 32'h00000000, 1'b1, '0, 1'b0);
        li_round = mk(4'd8, 5'd5, 5'd0, 5'd0, 3'd0, 32'h00003000, 1, 32'h00000000, 1'b1, '0, 1'b0);
`endif
        vecs.push_back(li_split);
        vecs.push_back(li_round);

        rst_n = 1'b0;
        req_valid_in = 1'b0;
        req_fmt_in = '0; req_rd_in = '0; req_rs1_in = '0; req_rs2_in = '0;
        req_funct3_in = '0; req_imm_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", {31'd0, instr_valid_out}, 32'd0);
        checkOutput("reset_instr", instr_out, 32'd0);
        checkOutput("reset_err", {31'd0, err_out}, 32'd0);
        checkOutput("reset_ready", {31'd0, req_ready_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", {31'd0, req_ready_out}, 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] table pass, downstream always ready");
        foreach (vecs[i]) applyStimulus(vecs[i], w);
        drain();

        $display("[TB] table pass, random downstream ready");
        ready_mode = 1;
        foreach (vecs[i]) applyStimulus(vecs[i], w);
        ready_mode = 0;
        drain();

        $display("[TB] backpressure and back-to-back throughput");
        ready_mode = 2;
        @(posedge clk);
        #2;
        applyStimulus(vecs[0], w);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("stall_instr", instr_out, vecs[0].instr0);
            checkOutput("stall_valid", {31'd0, instr_valid_out}, 32'd1);
            checkOutput("stall_req_ready", {31'd0, req_ready_out}, 32'd0);
        end
        ready_mode = 0;
        @(posedge clk);
        #2;
        bc = beat_count;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i], w);
            checkOutput("burst_accept_wait", 32'(w), 32'd0);
        end
        @(negedge clk);
        #1;
        checkOutput("burst_beats", 32'(beat_count - bc), 32'd5);
        drain();

`ifdef INSTR_ENC_LI_EN
        $display("[TB] LI sequences");
        applyStimulus(li_split, w);
        @(negedge clk);
        checkOutput("li_hi_req_ready", {31'd0, req_ready_out}, 32'd0);
        @(negedge clk);
        checkOutput("li_lo_req_ready", {31'd0, req_ready_out}, 32'd0);
        drain();
        applyStimulus(li_round, w);
        drain();
`endif

        $display("[TB] reset with a beat in flight");
        applyStimulus(li_split, w);
`ifdef INSTR_ENC_LI_EN
        @(negedge clk);
        @(posedge clk);
        #1;
`endif
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {31'd0, instr_valid_out}, 32'd0);
        checkOutput("midrst_instr", instr_out, 32'd0);
        checkOutput("midrst_req_ready", {31'd0, req_ready_out}, 32'd0);
        exp_q.delete();
        bc = beat_count;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready_after", {31'd0, req_ready_out}, 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("midrst_no_beat", 32'(beat_count - bc), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
